// File: rtl/cart_map_arbiter.sv
// Cartridge-bus arbiter: steers the SNES cartridge-side buses from one of
// N_MAP coprocessor mapper channels or the default channel (index N_MAP).
// A new selection is committed only after the candidate has been stable,
// the outgoing channel has drained, and one forced-idle gap cycle has passed.
//
// state | meaning
// RUN   | steady; candidate matches the selected channel
// PEND  | candidate differs; counting consecutive stable cycles
// DRAIN | commit decided; waiting for the old channel's strobes to go idle
// GAP   | one cycle of forced-idle bus before the new channel takes over
module cart_map_arbiter #(
  parameter int                N_MAP       = 5,
  parameter int                ROM_AW      = 24,
  parameter int                BSRAM_AW    = 20,
  parameter int                SETTLE      = 4,
  parameter int                DRAIN_MAX   = 16,
  parameter logic [N_MAP-1:0]  TURBO_BLOCK = 5'b01010,
  localparam int               NCH         = N_MAP + 1,
  localparam int               SEL_W       = $clog2(N_MAP + 1)
) (
  input  logic                    mclk,
  input  logic                    rst_n,
  input  logic [N_MAP-1:0]        map_active,
  input  logic [8*NCH-1:0]        ch_do,
  input  logic [NCH-1:0]          ch_irq_n,
  input  logic [ROM_AW*NCH-1:0]   ch_rom_addr,
  input  logic [NCH-1:0]          ch_rom_ce_n,
  input  logic [NCH-1:0]          ch_rom_oe_n,
  input  logic [NCH-1:0]          ch_rom_word,
  input  logic [BSRAM_AW*NCH-1:0] ch_bsram_addr,
  input  logic [8*NCH-1:0]        ch_bsram_d,
  input  logic [NCH-1:0]          ch_bsram_ce_n,
  input  logic [NCH-1:0]          ch_bsram_oe_n,
  input  logic [NCH-1:0]          ch_bsram_we_n,
  output logic [7:0]              di,
  output logic                    irq_n,
  output logic [ROM_AW-1:0]       rom_addr,
  output logic                    rom_ce_n,
  output logic                    rom_oe_n,
  output logic                    rom_word,
  output logic [BSRAM_AW-1:0]     bsram_addr,
  output logic [7:0]              bsram_d,
  output logic                    bsram_ce_n,
  output logic                    bsram_oe_n,
  output logic                    bsram_we_n,
  output logic [SEL_W-1:0]        sel_idx,
  output logic                    multi_hot_err,
  output logic                    turbo_allow,
  output logic                    switching
);

  localparam int CNT_W  = $clog2(SETTLE + 1);
  localparam int DCNT_W = $clog2(DRAIN_MAX + 1);

  localparam logic [SEL_W-1:0]  DEF_SEL   = SEL_W'(N_MAP);
  localparam logic [CNT_W-1:0]  SETTLE_C  = CNT_W'(SETTLE);
  localparam logic [DCNT_W-1:0] DMAX_M1   = DCNT_W'(DRAIN_MAX - 1);
  // Default channel never blocks turbo, so its bit is forced to zero.
  localparam logic [NCH-1:0]    TURBO_EXT = {1'b0, TURBO_BLOCK};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              mhe_q, mhe_d;
  logic              turbo_q, turbo_d;
  logic              switching_q, switching_d;

  logic [SEL_W-1:0]  cand;
  logic              multi_hot;
  logic              old_idle;
  logic [CNT_W-1:0]  cnt_inc;

  // Candidate: the one-hot bit index, otherwise the default channel.
  always_comb begin
    cand      = DEF_SEL;
    multi_hot = |(map_active & (map_active - N_MAP'(1)));
    for (int k = 0; k < N_MAP; k++) begin
      if (map_active == (N_MAP'(1) << k)) cand = SEL_W'(k);
    end
  end

  assign old_idle = ch_rom_ce_n[sel_q] & ch_bsram_ce_n[sel_q] & ch_bsram_we_n[sel_q];
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Next-state and registered-output computation for the switch sequencer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    mhe_d   = mhe_q | multi_hot;
    case (state_q)
      ST_RUN: begin
        if (cand != sel_q) begin
          pend_d  = cand;
          cnt_d   = CNT_W'(1);
          dcnt_d  = '0;
          state_d = (SETTLE == 1) ? ST_DRAIN : ST_PEND;
        end
      end
      ST_PEND: begin
        if (cand == pend_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= SETTLE_C) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end
        end else if (cand == sel_q) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          pend_d = cand;
          cnt_d  = CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        // Pending target is frozen here; only the drain timer advances.
        if (dcnt_q != DMAX_M1) dcnt_d = dcnt_q + DCNT_W'(1);
        if (old_idle || (dcnt_q == DMAX_M1)) state_d = ST_GAP;
      end
      ST_GAP: begin
        sel_d   = pend_q;
        state_d = ST_RUN;
        cnt_d   = '0;
        dcnt_d  = '0;
      end
      default: state_d = ST_RUN;
    endcase
    switching_d = (state_d != ST_RUN);
    turbo_d     = ~TURBO_EXT[sel_d];
  end

  // Sequencer state registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      sel_q       <= DEF_SEL;
      pend_q      <= DEF_SEL;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      mhe_q       <= 1'b0;
      turbo_q     <= 1'b1;
      switching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      mhe_q       <= mhe_d;
      turbo_q     <= turbo_d;
      switching_q <= switching_d;
    end
  end

  // Zero-latency steering of the selected slice; strobes forced idle in GAP.
  always_comb begin
    rom_addr   = ch_rom_addr[sel_q*ROM_AW +: ROM_AW];
    bsram_addr = ch_bsram_addr[sel_q*BSRAM_AW +: BSRAM_AW];
    bsram_d    = ch_bsram_d[sel_q*8 +: 8];
    if (state_q == ST_GAP) begin
      di         = 8'h00;
      irq_n      = 1'b1;
      rom_ce_n   = 1'b1;
      rom_oe_n   = 1'b1;
      rom_word   = 1'b0;
      bsram_ce_n = 1'b1;
      bsram_oe_n = 1'b1;
      bsram_we_n = 1'b1;
    end else begin
      di         = ch_do[sel_q*8 +: 8];
      irq_n      = ch_irq_n[sel_q];
      rom_ce_n   = ch_rom_ce_n[sel_q];
      rom_oe_n   = ch_rom_oe_n[sel_q];
      rom_word   = ch_rom_word[sel_q];
      bsram_ce_n = ch_bsram_ce_n[sel_q];
      bsram_oe_n = ch_bsram_oe_n[sel_q];
      bsram_we_n = ch_bsram_we_n[sel_q];
    end
  end

  assign sel_idx       = sel_q;
  assign multi_hot_err = mhe_q;
  assign turbo_allow   = turbo_q;
  assign switching     = switching_q;

endmodule

// File: tb/tb_cart_map_arbiter.sv
// Directed bench for cart_map_arbiter: switch latency, gap cycle, abort,
// drain timeout, multi-hot flag and reset during DRAIN.
module tb_cart_map_arbiter;

  localparam int N_MAP = 5;
  localparam int NCH   = 6;

  logic              mclk;
  logic              rst_n;
  logic [N_MAP-1:0]  map_active;
  logic [8*NCH-1:0]  ch_do;
  logic [NCH-1:0]    ch_irq_n;
  logic [24*NCH-1:0] ch_rom_addr;
  logic [NCH-1:0]    ch_rom_ce_n, ch_rom_oe_n, ch_rom_word;
  logic [20*NCH-1:0] ch_bsram_addr;
  logic [8*NCH-1:0]  ch_bsram_d;
  logic [NCH-1:0]    ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
  logic [7:0]        di;
  logic              irq_n;
  logic [23:0]       rom_addr;
  logic              rom_ce_n, rom_oe_n, rom_word;
  logic [19:0]       bsram_addr;
  logic [7:0]        bsram_d;
  logic              bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic [2:0]        sel_idx;
  logic              multi_hot_err, turbo_allow, switching;

  cart_map_arbiter dut (
    .mclk(mclk), .rst_n(rst_n), .map_active(map_active),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
    .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
    .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
    .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n),
    .rom_oe_n(rom_oe_n), .rom_word(rom_word), .bsram_addr(bsram_addr),
    .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n),
    .bsram_we_n(bsram_we_n), .sel_idx(sel_idx), .multi_hot_err(multi_hot_err),
    .turbo_allow(turbo_allow), .switching(switching)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  dat;
    logic        turbo;
    logic [23:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [23:0] rom_of(input int k);
    return 24'(k * 24'h111111 + 1);
  endfunction

  function automatic logic exp_turbo(input int s);
    logic [4:0] m;
    m = 5'b01010;
    if (s == 5) return 1'b1;
    return ~m[s];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a new map_active, follow the switch to completion, then score it.
  task automatic do_switch(input logic [4:0] ma, input int exp_sel,
                           input int exp_edges, input int exp_gap);
    int         e;
    int         gap;
    bit         done;
    logic [2:0] start;
    exp_t       x;
    start   = sel_idx;
    x.sel   = 3'(exp_sel);
    x.dat   = 8'(8'hA0 + exp_sel);
    x.turbo = exp_turbo(exp_sel);
    x.addr  = rom_of(exp_sel);
    sb_q.push_back(x);
    map_active = ma;
    e = 0; gap = 0; done = 0;
    while (!done && e < 60) begin
      @(negedge mclk);
      e++;
      if (e == 1) chk("switch_rise", switching, 1);
      if (di === 8'h00 && rom_ce_n === 1'b1) begin
        gap++;
        chk("gap_irq", irq_n, 1);
        chk("gap_word", rom_word, 0);
        chk("gap_addr", rom_addr, rom_of(start));
      end
      if (sel_idx !== start) done = 1;
    end
    chk("latency", e, exp_edges);
    chk("gap_cycles", gap, exp_gap);
    x = sb_q.pop_front();
    chk("new_sel", sel_idx, x.sel);
    chk("new_di", di, x.dat);
    chk("new_turbo", turbo_allow, x.turbo);
    chk("new_addr", rom_addr, x.addr);
    chk("switch_fall", switching, 0);
  endtask

  initial begin
    int forced;
    rst_n      = 1'b0;
    map_active = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_do[k*8 +: 8]          = 8'(8'hA0 + k);
      ch_rom_addr[k*24 +: 24]  = rom_of(k);
      ch_bsram_addr[k*20 +: 20] = 20'(k * 20'h11111 + 2);
      ch_bsram_d[k*8 +: 8]     = 8'(8'h50 + k);
    end
    ch_irq_n      = 6'b010101;
    ch_rom_word   = '1;
    ch_rom_ce_n   = '1;
    ch_rom_oe_n   = '1;
    ch_bsram_ce_n = '1;
    ch_bsram_oe_n = '1;
    ch_bsram_we_n = '1;

    // Reset state reflects the default channel.
    repeat (2) @(negedge mclk);
    chk("rst_sel", sel_idx, 5);
    chk("rst_di", di, 8'hA5);
    chk("rst_irq", irq_n, 0);
    chk("rst_addr", rom_addr, rom_of(5));
    chk("rst_bsram_d", bsram_d, 8'h55);
    chk("rst_turbo", turbo_allow, 1);
    chk("rst_switching", switching, 0);
    chk("rst_mhe", multi_hot_err, 0);
    rst_n = 1'b1;
    @(negedge mclk);

    // Normal switch to ch2 and back to default.
    do_switch(5'b00100, 2, 6, 1);
    do_switch(5'b00000, 5, 6, 1);

    // Candidate withdrawn before SETTLE: no switch, never forced idle.
    map_active = 5'b01000;
    forced = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      if (i == 0) chk("abort_pend", switching, 1);
    end
    map_active = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge mclk);
      if (di === 8'h00) forced++;
    end
    chk("abort_forced", forced, 0);
    chk("abort_sel", sel_idx, 5);
    chk("abort_switching", switching, 0);

    // Drain timeout: default channel's ROM stays busy.
    ch_rom_ce_n[5] = 1'b0;
    do_switch(5'b01000, 3, 21, 1);
    ch_rom_ce_n[5] = 1'b1;
    do_switch(5'b00000, 5, 6, 1);

    // Multi-hot selection sets a sticky flag cleared only by reset.
    map_active = 5'b00011;
    @(negedge mclk);
    chk("mhe_set", multi_hot_err, 1);
    chk("mhe_sel", sel_idx, 5);
    chk("mhe_switching", switching, 0);
    map_active = '0;
    repeat (3) @(negedge mclk);
    chk("mhe_sticky", multi_hot_err, 1);
    rst_n = 1'b0;
    #1;
    chk("mhe_clear", multi_hot_err, 0);
    @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);

    // Reset asserted while in DRAIN.
    ch_rom_ce_n[5] = 1'b0;
    map_active = 5'b00100;
    repeat (6) @(negedge mclk);
    chk("drain_switching", switching, 1);
    chk("drain_sel", sel_idx, 5);
    rst_n = 1'b0;
    #1;
    chk("drst_sel", sel_idx, 5);
    chk("drst_switching", switching, 0);
    chk("drst_di", di, 8'hA5);
    chk("drst_turbo", turbo_allow, 1);
    map_active     = '0;
    ch_rom_ce_n[5] = 1'b1;
    @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);
    chk("post_rst_switching", switching, 0);
    do_switch(5'b00010, 1, 6, 1);
    do_switch(5'b00000, 5, 6, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
